// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: sequences an external 4-bit ripple-carry adder slice to
// perform a WIDTH-bit add or subtract, one nibble per clock, LSB nibble first.
// The block owns the operand, carry-in and carry-chain registers; the adder
// itself sits outside and is reached through the add_* ports.
// Optional feature: define NIBBLE_ADD_SEQ_ACCUM_EN to add the 'acc' input,
// which selects the current result register as operand A (chained accumulate).
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
    input  logic             acc,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   opa_src;
    logic               clear_result;

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == RUN) && (idx_q == IDX_LAST);

    // Operand A source and whether acceptance clears the result register
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
    assign opa_src      = acc ? result_q : op_a;
    assign clear_result = ~acc;
`else
    assign opa_src      = op_a;
    assign clear_result = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for NIB steps, DONE for one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake from state, adder driven only while running
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            RUN: begin
                busy    = 1'b1;
                add_a   = opa_q[4*idx_q +: 4];
                add_b   = opb_q[4*idx_q +: 4];
                add_cin = carry_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

    // Datapath next values: operand capture on accept, nibble write-back in RUN
    always_comb begin
        idx_d       = idx_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1
            opa_d       = opa_src;
            opb_d       = sub ? ~op_b : op_b;
            carry_d     = sub;
            idx_d       = '0;
            carry_out_d = 1'b0;
            overflow_d  = 1'b0;
            if (clear_result) begin
                result_d = '0;
            end
        end else if (state_q == RUN) begin
            result_d[4*idx_q +: 4] = add_sum;
            carry_d                = add_cout;
            if (last_step) begin
                // Index holds at the last nibble rather than wrapping
                carry_out_d = add_cout;
                overflow_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (add_sum[3] != opa_q[WIDTH-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Testbench for nibble_add_sequencer (WIDTH=16). Models the external 4-bit
// adder, keeps a scoreboard of expected results pushed at start and popped on done.
module tb_nibble_add_sequencer;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              sub;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
    logic              acc;
`endif
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              carry_out;
    logic              overflow;
    logic [3:0]        add_a;
    logic [3:0]        add_b;
    logic              add_cin;
    logic [3:0]        add_sum;
    logic              add_cout;
    logic [4:0]        adder_full;

    always #5 clk = ~clk;

    // External combinational 4-bit adder slice
    assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_sum    = adder_full[3:0];
    assign add_cout   = adder_full[4];

    nibble_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
        .acc       (acc),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    int               done_seen = 0;
    logic [WIDTH-1:0] model_res;

    always @(posedge clk) begin
        if (done) done_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
        exp_t        e;
        logic [16:0] full;
        if (s) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   full = {1'b0, a} + {1'b0, b};
        e.res  = full[15:0];
        e.cout = full[16];
        if (s) e.ovf = (a[15] != b[15]) && (e.res[15] != a[15]);
        else   e.ovf = (a[15] == b[15]) && (e.res[15] != a[15]);
        return e;
    endfunction

    function automatic logic [28:0] all_outs();
        return {busy, done, result, carry_out, overflow, add_a, add_b, add_cin};
    endfunction

    // One operation starting from IDLE at a negedge; ends at the negedge after DONE
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic ac, input bit repulse, input string tag);
        exp_t             e;
        exp_t             got;
        logic [WIDTH-1:0] a_eff;
        logic [WIDTH-1:0] b_eff;
        int               n;
        int               busy_n;
        int               d0;
        a_eff = ac ? model_res : a;
        b_eff = s ? ~b : b;
        e = model(a_eff, b, s);
        model_res = e.res;
        sb.push_back(e);
        d0 = done_seen;

        start = 1'b1; sub = s; op_a = a; op_b = b;
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
        acc = ac;
`endif
        @(negedge clk);
        start = 1'b0; op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); sub = ~s;
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
        acc = ~ac;
`endif
        check({tag, "_busy_first"}, 32'(busy), 32'd1);
        check({tag, "_done_first"}, 32'(done), 32'd0);
        check({tag, "_cin_first"}, 32'(add_cin), 32'(s));
        check({tag, "_adda_first"}, 32'(add_a), 32'(a_eff[3:0]));
        check({tag, "_addb_first"}, 32'(add_b), 32'(b_eff[3:0]));

        busy_n = 1;
        n = 0;
        while (!done && n < 20) begin
            if (repulse && n == 1) begin
                start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1;
            end
            if (repulse && n == 2) start = 1'b0;
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end
        check({tag, "_done_latency"}, 32'(n), 32'(NIB));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(NIB));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);

        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(got.res));
            check({tag, "_carry_out"}, 32'(carry_out), 32'(got.cout));
            check({tag, "_overflow"}, 32'(overflow), 32'(got.ovf));
        end else begin
            check({tag, "_scoreboard_entry"}, 32'd0, 32'd1);
        end

        if (repulse) begin
            start = 1'b1; op_a = 16'h0F0F; op_b = 16'h0F0F; sub = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_adder"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
        check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
    endtask

    initial begin : stim
        int d;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
        acc = 1'b0;
`endif
        model_res = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {3'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", {3'd0, all_outs()}, 32'd0);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "add_1234");
        check("lit_5555", 32'(result), 32'h5555);
        check("lit_5555_flags", {30'd0, carry_out, overflow}, 32'd0);

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ffff");
        check("lit_0000", 32'(result), 32'h0000);
        check("lit_0000_flags", {30'd0, carry_out, overflow}, 32'b10);

        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, "sub_5_7");
        check("lit_fffe", 32'(result), 32'hFFFE);
        check("lit_fffe_flags", {30'd0, carry_out, overflow}, 32'b00);

        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, "sub_8000");
        check("lit_7fff", 32'(result), 32'h7FFF);
        check("lit_7fff_flags", {30'd0, carry_out, overflow}, 32'b11);

        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_7fff");
        check("lit_8000", 32'(result), 32'h8000);
        check("lit_8000_flags", {30'd0, carry_out, overflow}, 32'b01);

        do_op(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b1, "repulse");
        d = done_seen;
        repeat (8) @(negedge clk);
        check("repulse_no_extra_done", 32'(done_seen - d), 32'd0);
        check("repulse_result_held", 32'(result), 32'h2222);
        check("repulse_idle_busy", 32'(busy), 32'd0);

        // Abort mid-operation after the second RUN edge
        start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_partial_result", 32'(result), 32'h0045);
        check("abort_busy_before", 32'(busy), 32'd1);
        d = done_seen;
        rst_n = 1'b0;
        #1;
        check("abort_outputs_async", {3'd0, all_outs()}, 32'd0);
        model_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_seen - d), 32'd0);
        check("abort_outputs_after", {3'd0, all_outs()}, 32'd0);

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "after_abort");
        check("lit_0100", 32'(result), 32'h0100);

`ifdef NIBBLE_ADD_SEQ_ACCUM_EN
        do_op(16'hDEAD, 16'h0100, 1'b0, 1'b1, 1'b0, "accum");
        check("lit_0200", 32'(result), 32'h0200);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
